mantissa_align_sequencer: RTL and testbench

MANTISSA_ALIGN_SEQUENCER -- requirements
Module: mantissa_align_sequencer

---
 rtl/mantissa_align_sequencer_pkg.sv | 13 +
 rtl/mantissa_align_sequencer_exp_compare_diff.sv | 24 ++
 rtl/mantissa_align_sequencer.sv | 150 +++++++++++++++
 tb/tb_mantissa_align_sequencer.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/mantissa_align_sequencer_pkg.sv
// Shared constants for the mantissa alignment sequencer: FSM encoding and
// default operand widths.
package mantissa_align_sequencer_pkg;

  localparam int DEF_W  = 24;
  localparam int DEF_EW = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/mantissa_align_sequencer_exp_compare_diff.sv
// Combinational exponent comparator: picks the larger exponent and produces
// the absolute difference one bit wider than the exponents so it never wraps.
module exp_compare_diff #(
  parameter int EW = 8
) (
  input  logic [EW-1:0] exp_a,
  input  logic [EW-1:0] exp_b,
  output logic          swap,
  output logic [EW-1:0] exp_max,
  output logic [EW:0]   diff
);

  logic [EW:0] a_ext;
  logic [EW:0] b_ext;

  assign a_ext = {1'b0, exp_a};
  assign b_ext = {1'b0, exp_b};

  // Ties favour operand a, so swap only asserts on a strict b > a.
  assign swap    = (b_ext > a_ext);
  assign exp_max = swap ? exp_b : exp_a;
  assign diff    = swap ? (b_ext - a_ext) : (a_ext - b_ext);

endmodule

// File: rtl/mantissa_align_sequencer.sv
// Multi-cycle mantissa aligner: captures an operand pair, selects the larger
// exponent and right-shifts the other mantissa one bit per cycle with sticky.
module mantissa_align_sequencer
  import mantissa_align_sequencer_pkg::*;
#(
  parameter int W  = DEF_W,
  parameter int EW = DEF_EW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          ready,
  input  logic [EW-1:0] exp_a,
  input  logic [EW-1:0] exp_b,
  input  logic [W-1:0]  man_a,
  input  logic [W-1:0]  man_b,
  output logic          done,
  output logic          swap,
  output logic [EW-1:0] exp_out,
  output logic [W-1:0]  man_big,
  output logic [W-1:0]  man_small,
  output logic          sticky
);

  localparam int CW = $clog2(W + 1);

  logic [1:0]    state_q, state_d;
  logic [EW-1:0] cap_exp_a_q, cap_exp_a_d;
  logic [EW-1:0] cap_exp_b_q, cap_exp_b_d;
  logic [W-1:0]  cap_man_a_q, cap_man_a_d;
  logic [W-1:0]  cap_man_b_q, cap_man_b_d;
  logic          done_q, done_d;
  logic          swap_q, swap_d;
  logic [EW-1:0] exp_out_q, exp_out_d;
  logic [W-1:0]  man_big_q, man_big_d;
  logic [W-1:0]  man_small_q, man_small_d;
  logic          sticky_q, sticky_d;
  logic [CW-1:0] n_q, n_d;

  logic          cmp_swap;
  logic [EW-1:0] cmp_max;
  logic [EW:0]   cmp_diff;
  logic [CW-1:0] n_load;

  exp_compare_diff #(
    .EW(EW)
  ) u_cmp (
    .exp_a  (cap_exp_a_q),
    .exp_b  (cap_exp_b_q),
    .swap   (cmp_swap),
    .exp_max(cmp_max),
    .diff   (cmp_diff)
  );

  // Shifting by W or more already flushes everything into sticky.
  always_comb begin
    if (32'(cmp_diff) >= 32'(W)) begin
      n_load = CW'(W);
    end else begin
      n_load = CW'(cmp_diff);
    end
  end

  always_comb begin
    state_d     = state_q;
    cap_exp_a_d = cap_exp_a_q;
    cap_exp_b_d = cap_exp_b_q;
    cap_man_a_d = cap_man_a_q;
    cap_man_b_d = cap_man_b_q;
    swap_d      = swap_q;
    exp_out_d   = exp_out_q;
    man_big_d   = man_big_q;
    man_small_d = man_small_q;
    sticky_d    = sticky_q;
    n_d         = n_q;
    // The done pulse trails the DONE state by one edge.
    done_d      = (state_q == ST_DONE);

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cap_exp_a_d = exp_a;
          cap_exp_b_d = exp_b;
          cap_man_a_d = man_a;
          cap_man_b_d = man_b;
          state_d     = ST_LOAD;
        end
      end
      ST_LOAD: begin
        swap_d      = cmp_swap;
        exp_out_d   = cmp_max;
        man_big_d   = cmp_swap ? cap_man_b_q : cap_man_a_q;
        man_small_d = cmp_swap ? cap_man_a_q : cap_man_b_q;
        sticky_d    = 1'b0;
        n_d         = n_load;
        state_d     = (n_load != '0) ? ST_SHIFT : ST_DONE;
      end
      ST_SHIFT: begin
        man_small_d = man_small_q >> 1;
        sticky_d    = sticky_q | man_small_q[0];
        n_d         = n_q - CW'(1);
        if (n_q == CW'(1)) begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cap_exp_a_q <= '0;
      cap_exp_b_q <= '0;
      cap_man_a_q <= '0;
      cap_man_b_q <= '0;
      done_q      <= 1'b0;
      swap_q      <= 1'b0;
      exp_out_q   <= '0;
      man_big_q   <= '0;
      man_small_q <= '0;
      sticky_q    <= 1'b0;
      n_q         <= '0;
    end else begin
      state_q     <= state_d;
      cap_exp_a_q <= cap_exp_a_d;
      cap_exp_b_q <= cap_exp_b_d;
      cap_man_a_q <= cap_man_a_d;
      cap_man_b_q <= cap_man_b_d;
      done_q      <= done_d;
      swap_q      <= swap_d;
      exp_out_q   <= exp_out_d;
      man_big_q   <= man_big_d;
      man_small_q <= man_small_d;
      sticky_q    <= sticky_d;
      n_q         <= n_d;
    end
  end

  assign ready     = (state_q == ST_IDLE);
  assign done      = done_q;
  assign swap      = swap_q;
  assign exp_out   = exp_out_q;
  assign man_big   = man_big_q;
  assign man_small = man_small_q;
  assign sticky    = sticky_q;

endmodule

// File: tb/tb_mantissa_align_sequencer.sv
// Randomized self-checking bench for mantissa_align_sequencer against an
// arithmetic reference of the alignment result and latency.
module tb_mantissa_align_sequencer;

  localparam int W  = 24;
  localparam int EW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          ready;
  logic [EW-1:0] exp_a, exp_b;
  logic [W-1:0]  man_a, man_b;
  logic          done, swap, sticky;
  logic [EW-1:0] exp_out;
  logic [W-1:0]  man_big, man_small;

  int tests = 0;
  int fails = 0;

  // Reference results of the most recent operation.
  logic          m_swap, m_sticky;
  logic [EW-1:0] m_exp;
  logic [W-1:0]  m_big, m_small;
  int            m_lat;

  always #5 clk = ~clk;

  mantissa_align_sequencer #(.W(W), .EW(EW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .ready    (ready),
    .exp_a    (exp_a),
    .exp_b    (exp_b),
    .man_a    (man_a),
    .man_b    (man_b),
    .done     (done),
    .swap     (swap),
    .exp_out  (exp_out),
    .man_big  (man_big),
    .man_small(man_small),
    .sticky   (sticky)
  );

  task automatic check(input string tag, input longint unsigned got, input longint unsigned exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model(input int ea, input int eb, input longint ma, input longint mb);
    int     d;
    longint small_in;
    d = (ea >= eb) ? ea - eb : eb - ea;
    if (d > W) d = W;
    m_swap   = (eb > ea);
    m_exp    = m_swap ? EW'(eb) : EW'(ea);
    m_big    = m_swap ? W'(mb) : W'(ma);
    small_in = m_swap ? ma : mb;
    m_small  = W'(small_in >> d);
    m_sticky = ((small_in & ((64'd1 << d) - 1)) != 0);
    m_lat    = d + 2;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".swap"},      swap,      m_swap);
    check({tag, ".exp_out"},   exp_out,   m_exp);
    check({tag, ".man_big"},   man_big,   m_big);
    check({tag, ".man_small"}, man_small, m_small);
    check({tag, ".sticky"},    sticky,    m_sticky);
  endtask

  // Entered and left #1 after a rising edge; noise scrambles inputs and start
  // while the operation is busy.
  task automatic run_op(input string tag, input int ea, input int eb,
                        input longint ma, input longint mb, input bit noise);
    int k;
    bit busy_bad;
    for (int w = 0; w < 40 && !ready; w++) begin
      @(posedge clk); #1;
    end
    check({tag, ".ready_in"}, ready, 1);
    model(ea, eb, ma, mb);
    exp_a = EW'(ea); exp_b = EW'(eb); man_a = W'(ma); man_b = W'(mb);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    busy_bad = 1'b0;
    k = 0;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk); #1;
      k = c;
      if (done) break;
      if (ready) busy_bad = 1'b1;
      if (noise) begin
        start = 1'($urandom);
        exp_a = EW'($urandom); exp_b = EW'($urandom);
        man_a = W'($urandom);  man_b = W'($urandom);
      end
    end
    start = 1'b0;
    check({tag, ".latency"}, k, m_lat);
    check({tag, ".busy"}, busy_bad, 0);
    check({tag, ".ready_done"}, ready, 1);
    check_outputs(tag);
    $display("[TB] %s ea=%0d eb=%0d ma=%06h mb=%06h -> swap=%0d exp=%0d big=%06h small=%06h st=%0d lat=%0d",
             tag, ea, eb, ma, mb, swap, exp_out, man_big, man_small, sticky, k);
  endtask

  initial begin
    int ea, eb, r;
    rst = 1'b0; start = 1'b0;
    exp_a = '0; exp_b = '0; man_a = '0; man_b = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    check("rst.ready", ready, 1);
    check("rst.done", done, 0);
    m_swap = 0; m_exp = 0; m_big = 0; m_small = 0; m_sticky = 0;
    check_outputs("rst");

    run_op("basic", 10, 7, 64'hC00000, 64'h80000F, 1'b0);
    check("basic.ref_small", man_small, 64'h100001);
    check("basic.ref_lat", m_lat, 5);
    run_op("swap", 3, 5, 64'h800004, 64'hFFFFFF, 1'b0);
    check("swap.ref_small", man_small, 64'h200001);
    run_op("large", 200, 2, 64'h123456, 64'h000001, 1'b0);
    check("large.ref_lat", m_lat, 26);
    run_op("equal", 8'h7F, 8'h7F, 64'hABCDEF, 64'h876543, 1'b0);
    run_op("busy", 40, 30, 64'h9ABCDE, 64'hF0F0F1, 1'b1);

    // Outputs hold and done falls after one cycle when idle.
    @(posedge clk); #1;
    check("hold.done", done, 0);
    check_outputs("hold");

    // Reset during the third SHIFT cycle.
    exp_a = 8'd20; exp_b = 8'd5; man_a = W'(24'hFFFFFF); man_b = W'(24'hFFFFFF);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    check("midrst.ready", ready, 1);
    check("midrst.done", done, 0);
    m_swap = 0; m_exp = 0; m_big = 0; m_small = 0; m_sticky = 0;
    check_outputs("midrst");
    run_op("after_rst", 1, 0, 64'h800001, 64'hC00003, 1'b0);
    check("after_rst.ref_lat", m_lat, 3);

    for (int i = 0; i < 150; i++) begin
      ea = int'($urandom_range(0, 255));
      r  = int'($urandom_range(0, 3));
      if (r == 0) eb = ea;
      else if (r < 3) begin
        eb = ea + int'($urandom_range(0, 60)) - 30;
        if (eb < 0) eb = 0;
        if (eb > 255) eb = 255;
      end else eb = int'($urandom_range(0, 255));
      run_op($sformatf("rand%0d", i), ea, eb,
             longint'($urandom_range(0, 24'hFFFFFF)),
             longint'($urandom_range(0, 24'hFFFFFF)), 1'($urandom));
      // Sometimes leave a gap; otherwise the next start lands back-to-back.
      if ($urandom_range(0, 1) == 0) begin
        @(posedge clk); #1;
        check("gap.done", done, 0);
        check_outputs("gap");
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
